m_p2s: RTL

M_P2S -- requirements
Module: m_p2s

---
 rtl/m_p2s.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/m_p2s.sv
// -----------------------------------------------------------------------------
// m_p2s : parallel-to-serial UART transmitter (8 data bits, optional parity,
//         one stop bit, LSB first).
//
// Parameters
//   BPS_CNT     clock cycles per serial bit (2..65535)
//   PARITY_EN   1 inserts a parity bit between D7 and the stop bit
//   PARITY_ODD  0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
//
// Ports
//   i_clk       system clock, all state changes on the rising edge
//   i_rst       asynchronous active-high reset
//   i_tx_valid  byte request; accepted when o_tx_ready is high
//   i_tx_data   byte to send, captured only on acceptance
//   o_tx_ready  high only while idle (registered)
//   o_uart_tx   serial line, idle high (registered)
//   o_tx_done   one-cycle pulse in the first idle cycle after a frame
// -----------------------------------------------------------------------------
module m_p2s #(
    parameter int BPS_CNT    = 434,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_uart_tx,
    output logic       o_tx_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } t_state;

    localparam logic [15:0] LP_BIT_LAST = 16'(BPS_CNT - 1);
    localparam logic        LP_ODD      = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    localparam logic        LP_PAR_EN   = (PARITY_EN != 0) ? 1'b1 : 1'b0;

    // Parity over the latched byte; odd parity is the inverse of even parity.
    function automatic logic f_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    t_state      r_state;
    t_state      w_next_state;
    logic [15:0] r_bit_cnt;
    logic [15:0] w_next_cnt;
    logic [2:0]  r_idx;
    logic [2:0]  w_next_idx;
    logic [7:0]  r_shift;
    logic        w_load;
    logic        w_done;
    logic        w_bit_end;
    logic        w_next_tx;
    logic        r_uart_tx;
    logic        r_tx_ready;
    logic        r_tx_done;

    assign w_bit_end  = (r_bit_cnt == LP_BIT_LAST);
    assign o_uart_tx  = r_uart_tx;
    assign o_tx_ready = r_tx_ready;
    assign o_tx_done  = r_tx_done;

    // Next-state, bit-timing counter and data-index logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_bit_cnt;
        w_next_idx   = r_idx;
        w_load       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_cnt = 16'd0;
                w_next_idx = 3'd0;
                if (i_tx_valid) begin
                    w_next_state = S_START;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_next_cnt   = 16'd0;
                    w_next_idx   = 3'd0;
                    w_next_state = S_DATA;
                end else begin
                    w_next_cnt = r_bit_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_next_cnt = 16'd0;
                    if (r_idx == 3'd7) begin
                        w_next_idx = 3'd0;
                        if (LP_PAR_EN) begin
                            w_next_state = S_PARITY;
                        end else begin
                            w_next_state = S_STOP;
                        end
                    end else begin
                        w_next_idx = r_idx + 3'd1;
                    end
                end else begin
                    w_next_cnt = r_bit_cnt + 16'd1;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_next_cnt   = 16'd0;
                    w_next_state = S_STOP;
                end else begin
                    w_next_cnt = r_bit_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_next_cnt   = 16'd0;
                    w_next_state = S_IDLE;
                    w_done       = 1'b1;
                end else begin
                    w_next_cnt = r_bit_cnt + 16'd1;
                end
            end
            default: begin
                // Corrupted encoding: fall back to idle with the line high.
                w_next_state = S_IDLE;
                w_next_cnt   = 16'd0;
                w_next_idx   = 3'd0;
            end
        endcase
    end

    // Line value for the state being entered, so the flop shows it with no lag.
    always_comb begin
        w_next_tx = 1'b1;
        case (w_next_state)
            S_IDLE:   w_next_tx = 1'b1;
            S_START:  w_next_tx = 1'b0;
            S_DATA:   w_next_tx = r_shift[w_next_idx];
            S_PARITY: w_next_tx = f_parity(r_shift, LP_ODD);
            S_STOP:   w_next_tx = 1'b1;
            default:  w_next_tx = 1'b1;
        endcase
    end

    // FSM state, counters and latched byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 16'd0;
            r_idx     <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_state   <= w_next_state;
            r_bit_cnt <= w_next_cnt;
            r_idx     <= w_next_idx;
            if (w_load) begin
                r_shift <= i_tx_data;
            end else begin
                r_shift <= r_shift;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_uart_tx  <= 1'b1;
            r_tx_ready <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_uart_tx  <= w_next_tx;
            r_tx_ready <= (w_next_state == S_IDLE);
            r_tx_done  <= w_done;
        end
    end

endmodule
